bcd_converter: RTL and testbench
================================

// Module: bcd_converter
// PURPOSE
//  Iterative binary-to-BCD converter (shift-add-3, one bit per clock) feeding the 7-segment display driver.
//  Takes a WIDTH-bit unsigned value from the CPU display register and produces DIGITS packed BCD nibbles.
//  The driver's data input is wired directly to bcd_o, so the display shows decimal instead of hex.
// PARAMETERS
//  WIDTH   16  binary input width, in bits
//  DIGITS  4   BCD digits presented on bcd_o; bcd_o is DIGITS*4 bits wide
// PORTS
//  clk_i       in   1         system clock
//  rst_i       in   1         asynchronous, active-high reset
//  start_i     in   1         request a conversion of bin_i; accepted only when busy_o=0
//  bin_i       in   WIDTH     unsigned binary value, sampled on the accepting edge
//  busy_o      out  1         conversion in progress
//  valid_o     out  1         one-cycle pulse: new bcd_o/ovf_o available
//  bcd_o       out  DIGITS*4  packed BCD result; digit 0 occupies bits [3:0]; held until next result
//  ovf_o       out  1         value needs more than DIGITS digits; held with bcd_o
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy_o=0; valid_o=0; bcd_o=0; ovf_o=0; scratch cleared.
//  Scratch register: FULL=(WIDTH+2)/3 BCD digits plus a WIDTH-bit shift register.
//  FSM states:
//   IDLE: start_i=1 loads the shift register with bin_i, clears the BCD scratch and the bit counter -> CONV.
//   CONV: on each edge, add 3 to every scratch digit >=5, then shift {bcd,shift} left 1.
//         After WIDTH iterations -> IDLE.
//  Timing: start sampled at edge k. Iterations occur on edges k+1..k+WIDTH.
//   At edge k+WIDTH, bcd_o/ovf_o are updated and valid_o=1 for exactly one cycle. Latency = WIDTH cycles.
//  busy_o = (state==CONV); it is combinational from registered state.
//  start_i while busy_o=1: ignored, with no queueing. bin_i may change freely during CONV.
//  start_i in the valid_o cycle is accepted (state is already IDLE), giving back-to-back throughput of one result per WIDTH+1 cycles.
//  Overflow: ovf_o=1 iff any scratch digit with index >= DIGITS is nonzero.
//   Without saturation, bcd_o = low DIGITS digits (modulo 10^DIGITS).
//  If DIGITS >= FULL, ovf_o is constant 0 and the upper bcd_o digits are 0.
//  Counter width: $clog2(WIDTH+1). No arithmetic wraps inside a digit; the add-3 result is always <=12 before the shift.
// CONFIGURATION
//  Macro BCD_SATURATE_EN:
//   Defined: when ovf_o=1, bcd_o is forced to all-9 digits (e.g. 16'h9999). ovf_o still asserts.
//   Undefined: bcd_o is truncated modulo 10^DIGITS as above.
//  The macro has no other effect; timing is identical in both cases.
// STRUCTURE
//  Package display_pkg holds:
//   - localparam NIBBLE=4
//   - typedef enum logic {IDLE, CONV} bcd_state_t
//   - typedef logic [3:0] bcd_digit_t
//  Sub-module bcd_digit_adj (combinational: in>=5 ? in+3 : in) is instantiated FULL times via a generate loop.
//  All other logic stays in this module. There is a single always_ff with async reset, plus one always_comb.
// TESTING (WIDTH=16, DIGITS=4)
//  1. bin_i=1234, start pulse -> busy_o=1 for 16 cycles; valid_o on cycle 16; bcd_o=16'h1234; ovf_o=0.
//  2. bin_i=0, then 9999 -> results 16'h0000 and 16'h9999, ovf_o=0 for both.
//  3. bin_i=65535 -> ovf_o=1. bcd_o=16'h5535 without BCD_SATURATE_EN; 16'h9999 with it.
//  4. start (bin_i=42), then start (bin_i=7) at cycle 5 of CONV -> only one valid_o, with bcd_o=16'h0042.
//  5. start asserted in the valid_o cycle with bin_i=10000 -> the next result arrives 16 cycles later, ovf_o=1, bcd_o=16'h0000 (no SAT).
//  6. rst_i pulsed at cycle 8 of CONV -> all outputs 0 immediately. No valid_o follows; the next start converts normally.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the decimal display path.
package display_pkg;
  localparam int NIBBLE = 4;

  typedef enum logic {IDLE, CONV} bcd_state_t;

  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_converter_digit_adj.sv
// Shift-add-3 digit correction: a digit of 5 or more gets 3 added so the following left shift carries into the next decade.
module bcd_digit_adj
  import display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter, one bit per clock, WIDTH cycles per result.
// Optional macro BCD_SATURATE_EN: on overflow bcd_o shows all nines instead of the low digits.
module bcd_converter
  import display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         bin_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [DIGITS*NIBBLE-1:0] bcd_o,
  output logic                     ovf_o
);
  localparam int FULL = (WIDTH + 2) / 3;
  localparam int EXT  = (FULL > DIGITS) ? FULL : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  bcd_state_t                state_q;
  logic [FULL*NIBBLE-1:0]    scr_q;
  logic [FULL*NIBBLE-1:0]    scr_adj;
  logic [FULL*NIBBLE-1:0]    scr_d;
  logic [WIDTH-1:0]          shift_q;
  logic [WIDTH-1:0]          shift_d;
  logic [CW-1:0]             cnt_q;
  logic                      last;
  logic                      valid_q;
  logic                      ovf_q;
  logic                      ovf_d;
  logic [DIGITS*NIBBLE-1:0]  bcd_q;
  logic [DIGITS*NIBBLE-1:0]  bcd_d;
  logic [EXT*NIBBLE-1:0]     scr_ext;

  for (genvar i = 0; i < FULL; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(scr_q[i*NIBBLE +: NIBBLE]),
      .digit_o(scr_adj[i*NIBBLE +: NIBBLE])
    );
  end

  // Zero-extending to EXT digits makes the overflow test vanish when DIGITS covers every scratch digit.
  always_comb begin
    scr_d   = {scr_adj[FULL*NIBBLE-2:0], shift_q[WIDTH-1]};
    shift_d = shift_q << 1;
    scr_ext = (EXT*NIBBLE)'(scr_d);
    ovf_d   = |(scr_ext >> (DIGITS*NIBBLE));
    bcd_d   = scr_ext[DIGITS*NIBBLE-1:0];
`ifdef BCD_SATURATE_EN
    if (ovf_d) begin
      bcd_d = {DIGITS{4'd9}};
    end
`endif
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      scr_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q <= bin_i;
            scr_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          scr_q   <= scr_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q <= IDLE;
            valid_q <= 1'b1;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
          end
        end
      endcase
    end
  end

  assign busy_o  = (state_q == CONV);
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: vector table through a scoreboard plus abort, ignore and back-to-back sequences.
module tb_bcd_converter;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy;
  logic        valid;
  logic [15:0] bcd;
  logic        ovf;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];
  vec_t v;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nvalid = 0;
  int   n0;
  int   n;
  logic prev_valid = 1'b0;

  bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .bin_i  (bin),
    .busy_o (busy),
    .valid_o(valid),
    .bcd_o  (bcd),
    .ovf_o  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input vec_t x, input int c);
    exp_t e;
    e.bcd = x.bcd;
    e.ovf = x.ovf;
    e.cyc = c;
`ifdef BCD_SATURATE_EN
    if (x.ovf) e.bcd = 16'h9999;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      nvalid++;
      check("valid_pulse", {31'd0, prev_valid}, 0);
      check("busy_in_valid", {31'd0, busy}, 0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("bcd", {16'd0, bcd}, {16'd0, mon_e.bcd});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        check("latency", cyc - mon_e.cyc, WIDTH);
      end
    end
    prev_valid = valid;
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input vec_t x);
    wait_idle();
    start = 1'b1;
    bin   = x.bin;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(mk(x, cyc));
    check("busy_after_start", {31'd0, busy}, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    tbl[0] = '{16'd1234,  16'h1234, 1'b0};
    tbl[1] = '{16'd0,     16'h0000, 1'b0};
    tbl[2] = '{16'd9999,  16'h9999, 1'b0};
    tbl[3] = '{16'd65535, 16'h5535, 1'b1};
    tbl[4] = '{16'd100,   16'h0100, 1'b0};
    tbl[5] = '{16'd8,     16'h0008, 1'b0};
    tbl[6] = '{16'd50505, 16'h0505, 1'b1};
    tbl[7] = '{16'd59999, 16'h9999, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_bcd", {16'd0, bcd}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i]);
      drain();
    end

    // Reset mid-conversion: outputs clear at once and the aborted result never appears.
    wait_idle();
    start = 1'b1;
    bin   = 16'd1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, valid}, 0);
    check("abort_bcd", {16'd0, bcd}, 0);
    check("abort_ovf", {31'd0, ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = nvalid;
    repeat (25) @(negedge clk);
    check("abort_no_valid", nvalid - n0, 0);
    v = '{16'd9876, 16'h9876, 1'b0};
    issue(v);
    drain();

    // Start during CONV is ignored.
    n0 = nvalid;
    v = '{16'd42, 16'h0042, 1'b0};
    issue(v);
    repeat (5) @(negedge clk);
    start = 1'b1;
    bin   = 16'd7;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    drain();
    repeat (20) @(negedge clk);
    check("ignored_start", nvalid - n0, 1);

    // Start in the valid cycle is accepted for back-to-back throughput.
    v = '{16'd4321, 16'h4321, 1'b0};
    issue(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 40);
    check("b2b_valid_seen", {31'd0, valid}, 1);
    start = 1'b1;
    bin   = 16'd10000;
    @(posedge clk);
    #1;
    start = 1'b0;
    v = '{16'd10000, 16'h0000, 1'b1};
    sb.push_back(mk(v, cyc));
    check("b2b_busy", {31'd0, busy}, 1);
    drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
